// File: rtl/fetch_defs.sv
// ---------------------------------------------------------------------------
// fetch_defs
// Shared state encoding and counter sizing for the instruction fetch unit.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_defs;

  // Sequencer states; encodings are fixed so other blocks may decode them.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  // Width of the word-index counter; a single-word instruction still gets one bit.
  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_word_assembler.sv
// ---------------------------------------------------------------------------
// fetch_word_assembler
// Collects memory words into shadow slots and commits the whole instruction
// to the instruction register in one edge, so partial instructions never show.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_word_assembler #(
  parameter int MEM_WIDTH   = 8,
  parameter int INSTR_WORDS = 2,
  parameter int CNT_W       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic                         commit,
  input  logic [CNT_W-1:0]             wr_idx,
  input  logic [MEM_WIDTH-1:0]         wr_data,
  output logic [MEM_WIDTH*INSTR_WORDS-1:0] ir
);

  logic [MEM_WIDTH-1:0]             shadow [INSTR_WORDS];
  logic [MEM_WIDTH*INSTR_WORDS-1:0] ir_commit;

  for (genvar i = 0; i < INSTR_WORDS; i++) begin : g_slot
    // Slot write: only the slot addressed by the word counter is loaded.
    always_ff @(posedge clk) begin
      if (rst || clear) begin
        shadow[i] <= '0;
      end else if (wr_en && (wr_idx == CNT_W'(i))) begin
        shadow[i] <= wr_data;
      end
    end

    // Commit view: the word arriving this edge bypasses its slot so the
    // final word lands in the instruction register together with the rest.
    assign ir_commit[i*MEM_WIDTH +: MEM_WIDTH] =
      (wr_en && (wr_idx == CNT_W'(i))) ? wr_data : shadow[i];
  end

  // Instruction register: updated only when the last word is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir <= '0;
    end else if (commit) begin
      ir <= ir_commit;
    end
  end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetches one INSTR_WORDS-word instruction from word-wide memory, advancing
// the PC per captured word, with start/done handshake, unbounded memory wait
// states and PC load that aborts a fetch in progress.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_unit
  import fetch_defs::*;
#(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    MEM_WIDTH   = 8,
  parameter int                    INSTR_WORDS = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                             Clock,
  input  logic                             Reset,
  input  logic                             Start,
  input  logic                             PCLoad,
  input  logic [ADDR_WIDTH-1:0]            PCLoadValue,
  input  logic                             MemRdy,
  input  logic [MEM_WIDTH-1:0]             MemData,
  output logic                             MemReq,
  output logic [ADDR_WIDTH-1:0]            MemAddress,
  output logic [MEM_WIDTH*INSTR_WORDS-1:0] IROut,
  output logic [ADDR_WIDTH-1:0]            PCOut,
  output logic                             Busy,
  output logic                             Done
);

  localparam int              CNT_W    = cnt_width(INSTR_WORDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INSTR_WORDS - 1);

  fetch_state_t          state, state_next;
  logic [ADDR_WIDTH-1:0] pc, pc_next;
  logic [CNT_W-1:0]      count, count_next;
  logic                  capture;
  logic                  commit;
  logic                  clear_shadow;

  // State, PC and word counter registers; reset overrides every input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= RESET_PC;
      count <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      count <= count_next;
    end
  end

  // Next-state logic; PC load wins over Start and MemRdy in every state.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    count_next   = count;
    capture      = 1'b0;
    commit       = 1'b0;
    clear_shadow = 1'b0;

    if (PCLoad) begin
      pc_next      = PCLoadValue;
      state_next   = IDLE;
      count_next   = '0;
      clear_shadow = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            state_next = FETCH;
            count_next = '0;
          end
        end
        FETCH: begin
          // Without MemRdy everything holds: an unbounded wait state.
          if (MemRdy) begin
            capture = 1'b1;
            pc_next = pc + ADDR_WIDTH'(1);
            if (count == LAST_IDX) begin
              commit     = 1'b1;
              count_next = '0;
              state_next = DONE;
            end else begin
              count_next = count + CNT_W'(1);
            end
          end
        end
        DONE: begin
          // Back-to-back fetch keeps the pipeline at one instruction per
          // INSTR_WORDS+1 cycles.
          count_next = '0;
          state_next = Start ? FETCH : IDLE;
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  fetch_word_assembler #(
    .MEM_WIDTH   (MEM_WIDTH),
    .INSTR_WORDS (INSTR_WORDS),
    .CNT_W       (CNT_W)
  ) u_assembler (
    .clk     (Clock),
    .rst     (Reset),
    .clear   (clear_shadow),
    .wr_en   (capture),
    .commit  (commit),
    .wr_idx  (count),
    .wr_data (MemData),
    .ir      (IROut)
  );

  // Outputs are pure decodes of registered state.
  assign MemReq     = (state == FETCH);
  assign Busy       = (state == FETCH);
  assign Done       = (state == DONE);
  assign MemAddress = pc;
  assign PCOut      = pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed bench for instruction_fetch_unit: default 16/8/2 instance plus a
// 4-word, 16-bit instance for the mid-fetch reset case.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Memory contents for the 8-bit instance: fixed words at 0/1, otherwise
  // {a[3:0], ~a[3:0]}.
  function automatic logic [7:0] mem8(input logic [15:0] a);
    if (a == 16'h0000) return 8'hA5;
    if (a == 16'h0001) return 8'h3C;
    return {a[3:0], ~a[3:0]};
  endfunction

  // Memory contents for the 16-bit instance: {a[7:0], ~a[7:0]}.
  function automatic logic [15:0] mem16(input logic [15:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  // ---------------- default instance ----------------
  logic        rst, start, pcload, rdy;
  logic [15:0] pcval;
  logic [7:0]  mdata;
  logic        mreq, busy, done;
  logic [15:0] maddr, pcout;
  logic [15:0] ir;

  assign mdata = mem8(maddr);

  instruction_fetch_unit u_dut (
    .Clock       (clk),
    .Reset       (rst),
    .Start       (start),
    .PCLoad      (pcload),
    .PCLoadValue (pcval),
    .MemRdy      (rdy),
    .MemData     (mdata),
    .MemReq      (mreq),
    .MemAddress  (maddr),
    .IROut       (ir),
    .PCOut       (pcout),
    .Busy        (busy),
    .Done        (done)
  );

  // ---------------- 4-word, 16-bit instance ----------------
  logic        rst2, start2, pcload2, rdy2;
  logic [15:0] pcval2;
  logic [15:0] mdata2;
  logic        mreq2, busy2, done2;
  logic [15:0] maddr2, pcout2;
  logic [63:0] ir2;

  assign mdata2 = mem16(maddr2);

  instruction_fetch_unit #(
    .ADDR_WIDTH  (16),
    .MEM_WIDTH   (16),
    .INSTR_WORDS (4),
    .RESET_PC    (16'h0010)
  ) u_dut4 (
    .Clock       (clk),
    .Reset       (rst2),
    .Start       (start2),
    .PCLoad      (pcload2),
    .PCLoadValue (pcval2),
    .MemRdy      (rdy2),
    .MemData     (mdata2),
    .MemReq      (mreq2),
    .MemAddress  (maddr2),
    .IROut       (ir2),
    .PCOut       (pcout2),
    .Busy        (busy2),
    .Done        (done2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pcload = 1'b0; rdy = 1'b0; pcval = '0;
    rst2 = 1'b1; start2 = 1'b0; pcload2 = 1'b0; rdy2 = 1'b0; pcval2 = '0;
    // Start and MemRdy asserted during reset must be ignored.
    start = 1'b1; rdy = 1'b1;
    tick(); tick();
    check("rst_memreq", {63'd0, mreq}, 64'd0);
    check("rst_busy",   {63'd0, busy}, 64'd0);
    check("rst_done",   {63'd0, done}, 64'd0);
    check("rst_addr",   {48'd0, maddr}, 64'h0);
    check("rst_ir",     {48'd0, ir}, 64'h0);
    rst = 1'b0; rst2 = 1'b0;

    // ---- basic zero-wait fetch: start sampled at edge 0 ----
    start = 1'b1; rdy = 1'b1;
    tick();
    start = 1'b0;
    check("t1_c1_req",  {63'd0, mreq}, 64'd1);
    check("t1_c1_addr", {48'd0, maddr}, 64'h0000);
    tick();
    check("t1_c2_req",  {63'd0, mreq}, 64'd1);
    check("t1_c2_addr", {48'd0, maddr}, 64'h0001);
    check("t1_c2_ir",   {48'd0, ir}, 64'h0000);
    tick();
    check("t1_c3_done", {63'd0, done}, 64'd1);
    check("t1_c3_busy", {63'd0, busy}, 64'd0);
    check("t1_c3_ir",   {48'd0, ir}, 64'h3CA5);
    check("t1_c3_pc",   {48'd0, pcout}, 64'h0002);
    tick();
    check("t1_c4_done", {63'd0, done}, 64'd0);

    // ---- three wait cycles before each word: Done in cycle 9 ----
    start = 1'b1; rdy = 1'b0;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check($sformatf("t2_c%0d_req", c), {63'd0, mreq}, 64'd1);
      check($sformatf("t2_c%0d_addr", c), {48'd0, maddr}, (c <= 4) ? 64'h0002 : 64'h0003);
      check($sformatf("t2_c%0d_ir", c), {48'd0, ir}, 64'h3CA5);
      rdy = (c == 4 || c == 8);
      tick();
    end
    rdy = 1'b0;
    check("t2_c9_done", {63'd0, done}, 64'd1);
    check("t2_c9_ir",   {48'd0, ir}, 64'h3C2D);
    check("t2_c9_pc",   {48'd0, pcout}, 64'h0004);
    tick();

    // ---- PC load during the second word's wait aborts the fetch ----
    start = 1'b1; rdy = 1'b0;
    tick();
    start = 1'b0; rdy = 1'b1;
    tick();
    check("t3_w2_addr", {48'd0, maddr}, 64'h0005);
    rdy = 1'b0; pcload = 1'b1; pcval = 16'h0040;
    tick();
    pcload = 1'b0;
    check("t3_abort_busy", {63'd0, busy}, 64'd0);
    check("t3_abort_req",  {63'd0, mreq}, 64'd0);
    check("t3_abort_done", {63'd0, done}, 64'd0);
    check("t3_abort_ir",   {48'd0, ir}, 64'h3C2D);
    check("t3_abort_pc",   {48'd0, pcout}, 64'h0040);
    tick();
    check("t3_nodone", {63'd0, done}, 64'd0);
    start = 1'b1; rdy = 1'b1;
    tick();
    start = 1'b0;
    check("t3_f_addr0", {48'd0, maddr}, 64'h0040);
    tick();
    check("t3_f_addr1", {48'd0, maddr}, 64'h0041);
    tick();
    check("t3_f_done", {63'd0, done}, 64'd1);
    check("t3_f_ir",   {48'd0, ir}, 64'h1E0F);
    check("t3_f_pc",   {48'd0, pcout}, 64'h0042);

    // ---- PC wrap at 0xFFFF, PCLoad overriding a simultaneous Start ----
    pcload = 1'b1; pcval = 16'hFFFF; start = 1'b1;
    tick();
    pcload = 1'b0;
    check("t4_load_busy", {63'd0, busy}, 64'd0);
    tick();
    start = 1'b0;
    check("t4_addr0", {48'd0, maddr}, 64'hFFFF);
    tick();
    check("t4_addr1", {48'd0, maddr}, 64'h0000);
    tick();
    check("t4_done", {63'd0, done}, 64'd1);
    check("t4_ir",   {48'd0, ir}, 64'hA5F0);
    check("t4_pc",   {48'd0, pcout}, 64'h0001);

    // ---- Start held high: Done at cycles 3, 6, 9, addresses 0..5 ----
    pcload = 1'b1; pcval = 16'h0000;
    tick();
    pcload = 1'b0; start = 1'b1; rdy = 1'b1;
    tick();
    begin
      int a = 0;
      for (int c = 1; c <= 9; c++) begin
        if (c % 3 == 0) begin
          check($sformatf("t5_c%0d_done", c), {63'd0, done}, 64'd1);
          check($sformatf("t5_c%0d_ir", c), {48'd0, ir},
                (c == 3) ? 64'h3CA5 : (c == 6) ? 64'h3C2D : 64'h5A4B);
        end else begin
          check($sformatf("t5_c%0d_req", c), {63'd0, mreq}, 64'd1);
          check($sformatf("t5_c%0d_addr", c), {48'd0, maddr}, 64'(a));
          a++;
        end
        tick();
      end
    end
    start = 1'b0;
    tick();

    // ---- 4-word 16-bit instance: full fetch, then reset mid-fetch ----
    check("w4_rst_pc", {48'd0, pcout2}, 64'h0010);
    start2 = 1'b1; rdy2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick(); tick(); tick(); tick();
    check("w4_done", {63'd0, done2}, 64'd1);
    check("w4_ir",   ir2, 64'h13EC_12ED_11EE_10EF);
    check("w4_pc",   {48'd0, pcout2}, 64'h0014);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check("w4_mid_addr", {48'd0, maddr2}, 64'h0015);
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    check("w4_rst_ir",   ir2, 64'h0);
    check("w4_rst_pc2",  {48'd0, pcout2}, 64'h0010);
    check("w4_rst_req",  {63'd0, mreq2}, 64'd0);
    check("w4_rst_busy", {63'd0, busy2}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
